// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port numbering, output-VC state encoding and
// the flat output-VC index helper used by the allocator and state tracker.
package noc_pkg;

    localparam int N_EAST       = 0;
    localparam int N_NORTH      = 1;
    localparam int N_WEST       = 2;
    localparam int N_SOUTH      = 3;
    localparam int N_EXIT       = 4;
    localparam int DEF_CHANNELS = 12;

    typedef enum logic [1:0] {
        OVC_IDLE   = 2'd0,
        OVC_ACTIVE = 2'd1,
        OVC_DRAIN  = 2'd2
    } ovc_state_t;

    function automatic int ovid(input int port, input int vc, input int channels = DEF_CHANNELS);
        return port * channels + vc;
    endfunction

endpackage

// File: rtl/ovc_state_tracker_if.sv
// Bundle between the VC allocator / switch traversal stage, the downstream
// credit links and the output-VC state tracker.
interface ovc_state_tracker_if #(
    parameter int PORTS    = 5,
    parameter int CHANNELS = 12,
    parameter int VID_BITS = 6
);
    localparam int NUM_OVC = PORTS * CHANNELS;
    localparam int VCW     = $clog2(CHANNELS);

    logic [NUM_OVC-1:0]                alloc_gnt;
    logic [NUM_OVC-1:0][VID_BITS-1:0]  alloc_ovid;
    logic [PORTS-1:0]                  send_valid;
    logic [PORTS-1:0][VCW-1:0]         send_vc;
    logic [PORTS-1:0]                  send_tail;
    logic [PORTS-1:0]                  credit_valid;
    logic [PORTS-1:0][VCW-1:0]         credit_vc;
    logic [NUM_OVC-1:0]                ovid_avail;
    logic [NUM_OVC-1:0]                credit_avail;
    logic [NUM_OVC-1:0][VID_BITS-1:0]  owner;
    logic                              err;

    modport master (
        output alloc_gnt, alloc_ovid, send_valid, send_vc, send_tail,
               credit_valid, credit_vc,
        input  ovid_avail, credit_avail, owner, err
    );

    modport slave (
        input  alloc_gnt, alloc_ovid, send_valid, send_vc, send_tail,
               credit_valid, credit_vc,
        output ovid_avail, credit_avail, owner, err
    );

endinterface

// File: rtl/ovc_slot.sv
// State of a single output VC: IDLE/ACTIVE/DRAIN FSM, downstream credit
// counter and owning input VC. Reports protocol errors seen on this slot.
module ovc_slot
    import noc_pkg::*;
#(
    parameter int VID_BITS  = 6,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_hit_i,
    input  logic [VID_BITS-1:0] alloc_owner_i,
    input  logic                send_hit_i,
    input  logic                send_tail_i,
    input  logic                credit_hit_i,
    output logic                avail_o,
    output logic                credit_avail_o,
    output logic [VID_BITS-1:0] owner_o,
    output logic                err_o
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    ovc_state_t          state_q, state_d;
    logic [CW-1:0]       cred_q, cred_d;
    logic [VID_BITS-1:0] owner_q, owner_d;
    logic                avail_q, cavail_q;
    logic                send_ok, credit_ok;

    always_comb begin
        send_ok   = send_hit_i && (state_q != OVC_IDLE) && (cred_q != '0);
        credit_ok = credit_hit_i && (cred_q != FULL);
        err_o     = (alloc_hit_i && (state_q != OVC_IDLE))
                  || (send_hit_i && !send_ok)
                  || (credit_hit_i && !credit_ok);
        cred_d    = cred_q + CW'(credit_ok) - CW'(send_ok);
        state_d   = state_q;
        owner_d   = owner_q;
        case (state_q)
            OVC_IDLE: begin
                if (alloc_hit_i) begin
                    state_d = OVC_ACTIVE;
                    owner_d = alloc_owner_i;
                end
            end
            OVC_ACTIVE: begin
                if (send_ok && send_tail_i) begin
                    state_d = OVC_DRAIN;
                end
            end
            // Free only once every flit buffer downstream has been returned.
            OVC_DRAIN: begin
                if (cred_d == FULL) begin
                    state_d = OVC_IDLE;
                end
            end
            default: state_d = OVC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OVC_IDLE;
            cred_q   <= FULL;
            owner_q  <= '0;
            avail_q  <= 1'b1;
            cavail_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cred_q   <= cred_d;
            owner_q  <= owner_d;
            avail_q  <= (state_d == OVC_IDLE);
            cavail_q <= (cred_d != '0);
        end
    end

    assign avail_o        = avail_q;
    assign credit_avail_o = cavail_q;
    assign owner_o        = owner_q;

endmodule

// File: rtl/ovc_state_tracker.sv
// Output-VC state tracker: decodes allocation grants, departing flits and
// returned credits into per-slot hits and collects a sticky protocol error.
module ovc_state_tracker
    import noc_pkg::*;
#(
    parameter int PORTS     = 5,
    parameter int CHANNELS  = 12,
    parameter int VID_BITS  = 6,
    parameter int BUF_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    ovc_state_tracker_if.slave  bus
);
    localparam int NUM_OVC = PORTS * CHANNELS;
    localparam int VCW     = $clog2(CHANNELS);

    logic [NUM_OVC-1:0]               alloc_hit;
    logic [NUM_OVC-1:0][VID_BITS-1:0] alloc_win;
    logic                             alloc_range_err;
    logic                             alloc_multi_err;
    logic [NUM_OVC-1:0]               send_hit;
    logic [NUM_OVC-1:0]               send_tail_hit;
    logic [NUM_OVC-1:0]               credit_hit;
    logic [NUM_OVC-1:0]               slot_avail;
    logic [NUM_OVC-1:0]               slot_cavail;
    logic [NUM_OVC-1:0][VID_BITS-1:0] slot_owner;
    logic [NUM_OVC-1:0]               slot_err;
    logic                             err_d, err_q;

    // Ascending scan: the first requester claims a slot, later ones are dropped.
    always_comb begin
        alloc_hit       = '0;
        alloc_win       = '0;
        alloc_range_err = 1'b0;
        alloc_multi_err = 1'b0;
        for (int i = 0; i < NUM_OVC; i++) begin
            if (bus.alloc_gnt[i]) begin
                if (int'(bus.alloc_ovid[i]) >= NUM_OVC) begin
                    alloc_range_err = 1'b1;
                end
                for (int j = 0; j < NUM_OVC; j++) begin
                    if (bus.alloc_ovid[i] == VID_BITS'(j)) begin
                        if (alloc_hit[j]) begin
                            alloc_multi_err = 1'b1;
                        end else begin
                            alloc_hit[j] = 1'b1;
                            alloc_win[j] = VID_BITS'(i);
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        send_hit      = '0;
        send_tail_hit = '0;
        credit_hit    = '0;
        for (int p = 0; p < PORTS; p++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                send_hit[ovid(p, c, CHANNELS)]      = bus.send_valid[p] && (bus.send_vc[p] == VCW'(c));
                send_tail_hit[ovid(p, c, CHANNELS)] = bus.send_tail[p];
                credit_hit[ovid(p, c, CHANNELS)]    = bus.credit_valid[p] && (bus.credit_vc[p] == VCW'(c));
            end
        end
    end

    for (genvar j = 0; j < NUM_OVC; j++) begin : g_slot
        ovc_slot #(
            .VID_BITS  (VID_BITS),
            .BUF_DEPTH (BUF_DEPTH)
        ) u_slot (
            .clk            (clk),
            .rst            (rst),
            .alloc_hit_i    (alloc_hit[j]),
            .alloc_owner_i  (alloc_win[j]),
            .send_hit_i     (send_hit[j]),
            .send_tail_i    (send_tail_hit[j]),
            .credit_hit_i   (credit_hit[j]),
            .avail_o        (slot_avail[j]),
            .credit_avail_o (slot_cavail[j]),
            .owner_o        (slot_owner[j]),
            .err_o          (slot_err[j])
        );
    end

    assign err_d = err_q | alloc_range_err | alloc_multi_err | (|slot_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.ovid_avail   = slot_avail;
    assign bus.credit_avail = slot_cavail;
    assign bus.owner        = slot_owner;
    assign bus.err          = err_q;

endmodule
